// File: rtl/db_top_pkg.sv
// Shared definitions for the deblocking top-pixel RAM controllers.
// Both the read-side and the write-side initiators use these widths and state names.
package db_top_pkg;

  localparam int DB_TOP_DATA_WIDTH = 128;
  localparam int DB_TOP_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } db_top_state_e;

endpackage

// File: rtl/db_top_rd_fifo.sv
// Small synchronous FIFO that buffers RAM read data for the output stream.
// The head entry is visible combinationally; it reads as zero while the FIFO is empty.
module db_top_rd_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  // Storage is deliberately not reset; an empty FIFO masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/db_top_rd_ctrl.sv
// Read-side initiator for the deblocking top-pixel RAM: issues a read burst and
// streams the returned words downstream with valid/ready and a last marker.
module db_top_rd_ctrl
  import db_top_pkg::*;
#(
  parameter int DATA_WIDTH = DB_TOP_DATA_WIDTH,
  parameter int ADDR_WIDTH = DB_TOP_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_cen_o,
  output logic                  ram_ren_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]      CRED_ONE = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0]      DEPTH_L  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  db_top_state_e         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH:0]   issue_cnt_reg, issue_cnt_next;
  logic [ADDR_WIDTH:0]   out_cnt_reg, out_cnt_next;
  logic                  inflight_reg;
  logic                  done_reg, done_next;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [CNT_W:0]   credit_sum;
  logic             issue;
  logic             pop;

  db_top_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (ram_data_i),
    .pop       (pop),
    .pop_data  (data_o),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // A read may issue only if its word is guaranteed a FIFO slot, counting the one in flight.
  assign credit_sum = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg} + CRED_ONE;
  assign issue      = (state_reg == ISSUE) && (credit_sum <= DEPTH_L);

  assign valid_o    = !fifo_empty;
  assign pop        = valid_o && ready_i;
  assign last_o     = valid_o && (out_cnt_reg == LEN_ONE);
  assign busy_o     = (state_reg != IDLE);
  assign done_o     = done_reg;
  assign ram_cen_o  = !issue;
  assign ram_ren_o  = !inflight_reg;
  assign ram_wen_o  = 1'b1;
  assign ram_addr_o = addr_reg;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    issue_cnt_next = issue_cnt_reg;
    out_cnt_next   = out_cnt_reg;
    done_next      = 1'b0;
    if (pop) begin
      out_cnt_next = out_cnt_reg - LEN_ONE;
    end
    case (state_reg)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_next     = ISSUE;
          addr_next      = base_addr_i;
          issue_cnt_next = len_i;
          out_cnt_next   = len_i;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_next      = addr_reg + ADDR_ONE;
          issue_cnt_next = issue_cnt_reg - LEN_ONE;
          if (issue_cnt_reg == LEN_ONE) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && last_o) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      issue_cnt_reg <= '0;
      out_cnt_reg   <= '0;
      inflight_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      issue_cnt_reg <= issue_cnt_next;
      out_cnt_reg   <= out_cnt_next;
      inflight_reg  <= issue;
      done_reg      <= done_next;
    end
  end

endmodule

// File: tb/tb_db_top_rd_ctrl.sv
// Self-checking bench for db_top_rd_ctrl: a behavioural RAM plus an expected-stream
// model (word i of a burst is mem[(base+i) mod 32]) checked per scenario.
module tb_db_top_rd_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [4:0]   base_addr_i = '0;
  logic [5:0]   len_i = '0;
  logic         busy_o, done_o, ram_cen_o, ram_ren_o, ram_wen_o;
  logic [4:0]   ram_addr_o;
  logic [127:0] ram_data_i;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [127:0] data_o;
  logic         last_o;

  always #5 clk = ~clk;

  db_top_rd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ram_cen_o   (ram_cen_o),
    .ram_ren_o   (ram_ren_o),
    .ram_wen_o   (ram_wen_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_i  (ram_data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o)
  );

  // Behavioural RAM: data is only driven in the cycle after a read issue.
  logic [127:0] mem [32];
  logic [127:0] ram_q;
  logic         rd_valid = 1'b0;
  always @(posedge clk) begin
    rd_valid <= !ram_cen_o;
    if (!ram_cen_o) ram_q <= mem[ram_addr_o];
  end
  assign ram_data_i = rd_valid ? ram_q : 'x;

  int checks = 0;
  int errors = 0;

  // Observations collected by run_burst
  logic [127:0] got_data[$];
  bit           got_last[$];
  int           got_cyc[$];
  logic [4:0]   iss_addr[$];
  int           iss_cyc[$];
  int           done_cyc, done_cnt, busy_low_cyc, proto_err, max_out;
  bit           timed_out;
  logic [127:0] head_c8;

  // rmode: 0 ready always high, 1 random ready, 2 ready low in cycles 3..8
  task automatic run_burst(input logic [4:0] base, input logic [5:0] len, input int rmode,
                           input int inj_cyc, input logic [4:0] inj_base, input logic [5:0] inj_len);
    int c = 0;
    int issued = 0;
    int accepted = 0;
    bit prev_issue = 0;
    bit prev_stall = 0;
    logic [127:0] prev_data = '0;
    got_data.delete(); got_last.delete(); got_cyc.delete();
    iss_addr.delete(); iss_cyc.delete();
    done_cyc = -1; done_cnt = 0; busy_low_cyc = -1; proto_err = 0; max_out = 0;
    timed_out = 0; head_c8 = '0;
    @(negedge clk);
    start_i = 1'b1; base_addr_i = base; len_i = len; ready_i = 1'b0;
    while (1) begin
      @(negedge clk);
      c++;
      start_i     = (c == inj_cyc);
      base_addr_i = (c == inj_cyc) ? inj_base : base;
      len_i       = (c == inj_cyc) ? inj_len : len;
      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = ($urandom_range(0, 9) < 7);
        default: ready_i = !(c >= 3 && c <= 8);
      endcase
      if (ram_ren_o !== !prev_issue) proto_err++;
      if (ram_wen_o !== 1'b1) proto_err++;
      if (prev_stall && (valid_o !== 1'b1 || data_o !== prev_data)) proto_err++;
      if (last_o && !valid_o) proto_err++;
      if (ram_cen_o == 1'b0) begin
        iss_addr.push_back(ram_addr_o); iss_cyc.push_back(c); issued++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (c == 8) head_c8 = data_o;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy_low_cyc < 0 && !busy_o) busy_low_cyc = c;
      if (valid_o && ready_i) begin
        got_data.push_back(data_o); got_last.push_back(last_o); got_cyc.push_back(c);
        accepted++;
      end
      prev_issue = !ram_cen_o;
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      if (c >= 400) begin timed_out = 1; break; end
    end
    start_i = 1'b0; ready_i = 1'b0;
    $display("burst base=%0d len=%0d words=%0d reads=%0d done_cycle=%0d", base, len,
             got_data.size(), iss_addr.size(), done_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_cen_o, ram_ren_o, ram_wen_o, ram_addr_o, valid_o, last_o, busy_o, done_o} !== 12'b111_00000_0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b required %b",
               {ram_cen_o, ram_ren_o, ram_wen_o, ram_addr_o, valid_o, last_o, busy_o, done_o}, 12'b111_00000_0000);
    end
    checks++;
    if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h required 0", data_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_burst(5'd3, 6'd4, 0, 0, 5'd0, 6'd0);
    checks++;
    if (timed_out || iss_addr.size() != 4 || got_data.size() != 4) begin
      errors++;
      $display("FAIL basic_sizes got reads=%0d words=%0d timeout=%0d required 4 4 0", iss_addr.size(), got_data.size(), timed_out);
    end
    foreach (iss_addr[i]) begin
      checks++;
      if (iss_addr[i] !== 5'(3 + i) || iss_cyc[i] != i + 1) begin
        errors++;
        $display("FAIL basic_addr[%0d] got %0d@%0d required %0d@%0d", i, iss_addr[i], iss_cyc[i], 3 + i, i + 1);
      end
    end
    foreach (got_data[i]) begin
      checks++;
      if (got_data[i] !== 128'hA0 + 128'(3 + i) || got_cyc[i] != 3 + i || got_last[i] != (i == 3)) begin
        errors++;
        $display("FAIL basic_word[%0d] got %h@%0d last=%0d required %h@%0d last=%0d", i, got_data[i], got_cyc[i],
                 got_last[i], 128'hA0 + 128'(3 + i), 3 + i, (i == 3));
      end
    end
    checks++;
    if (done_cyc != 7 || done_cnt != 1 || busy_low_cyc != 7 || proto_err != 0) begin
      errors++;
      $display("FAIL basic_done got done@%0d x%0d busy_low@%0d proto=%0d required 7 1 7 0", done_cyc, done_cnt, busy_low_cyc, proto_err);
    end
  endtask

  task automatic test_wrap();
    run_burst(5'd30, 6'd4, 0, 0, 5'd0, 6'd0);
    checks++;
    if (timed_out || iss_addr.size() != 4 || got_data.size() != 4 || done_cyc != 7 || proto_err != 0) begin
      errors++;
      $display("FAIL wrap_sizes got reads=%0d words=%0d done@%0d proto=%0d required 4 4 7 0", iss_addr.size(), got_data.size(), done_cyc, proto_err);
    end
    foreach (iss_addr[i]) begin
      checks++;
      if (iss_addr[i] !== 5'((30 + i) % 32)) begin
        errors++; $display("FAIL wrap_addr[%0d] got %0d required %0d", i, iss_addr[i], (30 + i) % 32);
      end
    end
    foreach (got_data[i]) begin
      checks++;
      if (got_data[i] !== 128'hA0 + 128'((30 + i) % 32) || got_last[i] != (i == 3)) begin
        errors++;
        $display("FAIL wrap_word[%0d] got %h last=%0d required %h last=%0d", i, got_data[i], got_last[i], 128'hA0 + 128'((30 + i) % 32), (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int early = 0;
    run_burst(5'd0, 6'd8, 2, 0, 5'd0, 6'd0);
    foreach (iss_cyc[i]) if (iss_cyc[i] <= 8) early++;
    checks++;
    if (early > 4 || max_out > 4) begin
      errors++; $display("FAIL bp_credit got reads_by_c8=%0d outstanding=%0d required <=4 <=4", early, max_out);
    end
    checks++;
    if (head_c8 !== 128'hA0) begin errors++; $display("FAIL bp_hold got %h required a0", head_c8); end
    checks++;
    if (timed_out || got_data.size() != 8 || iss_addr.size() != 8 || proto_err != 0) begin
      errors++;
      $display("FAIL bp_sizes got words=%0d reads=%0d proto=%0d required 8 8 0", got_data.size(), iss_addr.size(), proto_err);
    end
    foreach (got_data[i]) begin
      checks++;
      if (got_data[i] !== 128'hA0 + 128'(i) || got_cyc[i] != 9 + i || got_last[i] != (i == 7)) begin
        errors++;
        $display("FAIL bp_word[%0d] got %h@%0d last=%0d required %h@%0d last=%0d", i, got_data[i], got_cyc[i], got_last[i],
                 128'hA0 + 128'(i), 9 + i, (i == 7));
      end
    end
    checks++;
    if (done_cyc != 17 || done_cnt != 1) begin
      errors++; $display("FAIL bp_done got done@%0d x%0d required 17 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_full_ram();
    run_burst(5'd0, 6'd32, 0, 0, 5'd0, 6'd0);
    checks++;
    if (timed_out || got_data.size() != 32 || iss_addr.size() != 32 || proto_err != 0) begin
      errors++;
      $display("FAIL full_sizes got words=%0d reads=%0d proto=%0d required 32 32 0", got_data.size(), iss_addr.size(), proto_err);
    end
    foreach (got_data[i]) begin
      checks++;
      if (got_data[i] !== 128'hA0 + 128'(i) || got_cyc[i] != 3 + i || got_last[i] != (i == 31)) begin
        errors++;
        $display("FAIL full_word[%0d] got %h@%0d last=%0d required %h@%0d last=%0d", i, got_data[i], got_cyc[i], got_last[i],
                 128'hA0 + 128'(i), 3 + i, (i == 31));
      end
    end
    checks++;
    if (done_cyc != 35 || done_cnt != 1) begin
      errors++; $display("FAIL full_done got done@%0d x%0d required 35 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_ignored();
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 5'd7; len_i = 6'd0;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (busy_o !== 1'b0 || ram_cen_o !== 1'b1) begin
        errors++; $display("FAIL len0_idle cycle %0d got busy=%b cen=%b required 0 1", c, busy_o, ram_cen_o);
      end
      @(negedge clk);
    end
    $display("burst base=7 len=0 ignored");
    run_burst(5'd5, 6'd6, 0, 3, 5'd20, 6'd3);
    checks++;
    if (timed_out || iss_addr.size() != 6 || got_data.size() != 6 || done_cyc != 9 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start_sizes got reads=%0d words=%0d done@%0d x%0d required 6 6 9 1", iss_addr.size(), got_data.size(), done_cyc, done_cnt);
    end
    foreach (got_data[i]) begin
      checks++;
      if (iss_addr[i] !== 5'(5 + i) || got_data[i] !== 128'hA0 + 128'(5 + i) || got_last[i] != (i == 5)) begin
        errors++;
        $display("FAIL busy_start_word[%0d] got addr=%0d %h last=%0d required %0d %h %0d", i, iss_addr[i], got_data[i], got_last[i],
                 5 + i, 128'hA0 + 128'(5 + i), (i == 5));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 5'd0; len_i = 6'd8; ready_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_cen_o, ram_ren_o, ram_wen_o, ram_addr_o, valid_o, last_o, busy_o, done_o} !== 12'b111_00000_0000 || data_o !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %b data=%h required %b data=0",
               {ram_cen_o, ram_ren_o, ram_wen_o, ram_addr_o, valid_o, last_o, busy_o, done_o}, data_o, 12'b111_00000_0000);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL midreset_quiet cycle %0d got done=%b valid=%b busy=%b required 0 0 0", c, done_o, valid_o, busy_o);
      end
    end
    ready_i = 1'b0;
    $display("burst base=0 len=8 abandoned by reset");
    run_burst(5'd9, 6'd5, 0, 0, 5'd0, 6'd0);
    checks++;
    if (timed_out || got_data.size() != 5 || done_cyc != 8 || done_cnt != 1 || proto_err != 0) begin
      errors++;
      $display("FAIL midreset_after got words=%0d done@%0d x%0d proto=%0d required 5 8 1 0", got_data.size(), done_cyc, done_cnt, proto_err);
    end
    foreach (got_data[i]) begin
      checks++;
      if (got_data[i] !== 128'hA0 + 128'(9 + i) || got_last[i] != (i == 4)) begin
        errors++; $display("FAIL midreset_word[%0d] got %h required %h", i, got_data[i], 128'hA0 + 128'(9 + i));
      end
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 32; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 8; b++) begin
      logic [4:0] base = 5'($urandom_range(0, 31));
      logic [5:0] len  = 6'($urandom_range(1, 32));
      int n = int'(len);
      run_burst(base, len, 1, 0, 5'd0, 6'd0);
      checks++;
      if (timed_out || got_data.size() != n || iss_addr.size() != n || proto_err != 0 || max_out > 4) begin
        errors++;
        $display("FAIL rand%0d_sizes got words=%0d reads=%0d proto=%0d outstanding=%0d required %0d %0d 0 <=4", b,
                 got_data.size(), iss_addr.size(), proto_err, max_out, n, n);
      end
      foreach (got_data[i]) begin
        checks++;
        if (got_data[i] !== mem[(int'(base) + i) % 32] || got_last[i] != (i == n - 1) || iss_addr[i] !== 5'(int'(base) + i)) begin
          errors++;
          $display("FAIL rand%0d_word[%0d] got %h last=%0d addr=%0d required %h last=%0d addr=%0d", b, i, got_data[i], got_last[i],
                   iss_addr[i], mem[(int'(base) + i) % 32], (i == n - 1), (int'(base) + i) % 32);
        end
      end
      checks++;
      if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size() - 1] + 1 || done_cnt != 1 || busy_low_cyc != done_cyc) begin
        errors++; $display("FAIL rand%0d_done got done@%0d x%0d busy_low@%0d", b, done_cyc, done_cnt, busy_low_cyc);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 32; a++) mem[a] = 128'hA0 + 128'(a);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_full_ram();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/db_top_rd_ctrl.md
Name: db_top_rd_ctrl

Overview:
- Read-side initiator for the deblocking top-pixel RAM (32 x 128-bit, low-active cen/ren/wen, 1-cycle registered read).
- On a start command, issues a burst of reads on one RAM port and absorbs the RAM read latency.
- Presents the burst as a valid/ready stream to the deblocking filter datapath, with backpressure and a last-word marker.

Parameters:
- DATA_WIDTH, 128, RAM word width and stream data width.
- ADDR_WIDTH, 5, RAM address width; burst addresses wrap modulo 2^ADDR_WIDTH.
- FIFO_DEPTH, 4, output buffer entries; must be a power of two and at least 3.

Ports:
- clk  in  1  single clock for the block and its RAM port.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle burst request; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first RAM address of the burst.
- len_i  in  ADDR_WIDTH+1  word count, 1..2^ADDR_WIDTH; 0 is ignored.
- busy_o  out  1  burst in progress.
- done_o  out  1  one-cycle pulse after the last word is accepted downstream.
- ram_cen_o  out  1  RAM chip enable, low active.
- ram_ren_o  out  1  RAM output enable, low active.
- ram_wen_o  out  1  RAM write enable, low active; tied high (read-only initiator).
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_data_i  in  DATA_WIDTH  RAM read data; valid only in the cycle after a read issue.
- valid_o  out  1  stream word available.
- ready_i  in  1  downstream accepts the word.
- data_o  out  DATA_WIDTH  stream word (FIFO head).
- last_o  out  1  data_o is the final word of the burst.

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - state=IDLE; FIFO flushed; counters cleared; in-flight flag cleared.
  - ram_cen_o=1, ram_ren_o=1, ram_wen_o=1, ram_addr_o=0.
  - valid_o=0, data_o=0, last_o=0, busy_o=0, done_o=0.
  - Reset mid-burst abandons the burst; no done_o.
- FSM states:
  - IDLE: start_i=1 and len_i!=0 -> ISSUE. Latch base_addr_i into the address counter, latch len_i into issue_cnt and out_cnt, set busy_o=1.
  - IDLE: start_i with len_i=0 -> no action.
  - ISSUE -> DRAIN on the cycle the final read issues (issue_cnt reaches 0).
  - DRAIN -> IDLE on the edge where the last word is accepted (valid_o & ready_i & last_o). done_o=1 for exactly the next cycle; busy_o=0 in that same cycle.
  - start_i outside IDLE is ignored.
- Read issue (ISSUE only):
  - The issue condition is fifo_count + inflight + 1 <= FIFO_DEPTH. inflight=1 when a read issued in the previous cycle.
  - Issuing drives ram_cen_o=0 with ram_addr_o=current address, combinationally in that cycle.
  - Address increments by 1 and wraps from 2^ADDR_WIDTH-1 to 0; issue_cnt decrements.
- Read return:
  - ram_ren_o=0 exactly in the cycle after an issue, otherwise 1.
  - ram_data_i is pushed into the FIFO at the end of that cycle.
  - ram_data_i is never sampled in any other cycle; the RAM drives X/Z then.
- Stream output:
  - valid_o = FIFO not empty; data_o = FIFO head.
  - Pop on valid_o & ready_i.
  - last_o = valid_o & (out_cnt==1); out_cnt decrements on each pop.
  - data_o is held stable while valid_o & !ready_i.
- Timing:
  - start sampled at edge E0; first ram_cen_o=0 in cycle 1; ram_ren_o=0 in cycle 2; valid_o=1 in cycle 3.
  - With ready_i held high, throughput is 1 word/cycle; an N-word burst has its last handshake in cycle N+2 and done_o in cycle N+3.
- Simultaneous push and pop in the same cycle: fifo_count is unchanged. The FIFO can never overflow, because the credit rule guarantees it.
- len=2^ADDR_WIDTH reads the whole RAM once starting at base_addr_i, with wrap-around.

Decomposition:
- Package db_top_pkg:
  - DB_TOP_DATA_WIDTH=128, DB_TOP_ADDR_WIDTH=5.
  - FSM state typedef: IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2.
  - Shared with the future write-side controller.
- Sub-module db_top_rd_fifo: synchronous FIFO, FIFO_DEPTH x DATA_WIDTH, push/pop/count/empty, reset by rst.
- Credit logic and FSM stay in db_top_rd_ctrl.

Test Plan:
- Bench uses a behavioural model of the RAM, preloaded with mem[a]=128'hA0+a.
- Basic burst: base=3, len=4, ready_i=1 -> ram_addr_o 3,4,5,6 in cycles 1-4; valid_o cycles 3-6 with data A3..A6; last_o with A6; done_o in cycle 7.
- Wrap: base=30, len=4 -> addresses 30,31,0,1; data BE,BF,A0,A1; last_o on A1.
- Backpressure: base=0, len=8, ready_i low in cycles 3-8 -> at most 4 reads issue before stalling; data_o holds A0 while stalled; all 8 words delivered in order; no word dropped or duplicated.
- Full RAM: len=32, base=0, ready_i=1 -> 32 words A0..BF back-to-back with no gaps; ram_wen_o stays 1 throughout.
- Ignored commands: len=0 start -> busy_o stays 0; a second start_i during a busy burst -> no effect on counts or addresses.
- Reset mid-burst: rst=1 in cycle 4 of a len=8 burst -> next cycle all outputs at reset values, FIFO empty, no done_o; a new burst afterwards runs correctly.
